// File: rtl/cdc_sched_pkg.sv
// Shared types and helpers for the CDC pulse scheduler.
// Holds the FSM state encoding, the timer width rule and the round-robin index step.
package cdc_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LAUNCH   = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_GAP      = 2'd3
   } sched_state_e;

   // Width of a counter that must hold values 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int next_idx(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cdc_pulse_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
// Searches ptr+1, ptr+2, ... with wrap and returns the first requester found.
module rr_arbiter
   import cdc_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]  idx_o,
   output logic             vld_o
);

   logic [ID_W-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      cand  = ptr_i;
      for (int i = 0; i < N_REQ; i++) begin
         cand = ID_W'(next_idx(int'(cand), N_REQ));
         if (!vld_o && req_i[cand]) begin
            vld_o       = 1'b1;
            idx_o       = cand;
            gnt_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdc_pulse_scheduler.sv
// Round-robin scheduler sharing one toggle-synchronizer pulse channel between requesters.
// Launches one pulse per grant, waits for the returned ack (with timeout), then idles GAP cycles.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | arbitrating; latches winner's payload/index on a request
//   ST_LAUNCH   | one cycle: pulse_o and grant_o asserted
//   ST_WAIT_ACK | counting cycles until ack_i or TIMEOUT expiry
//   ST_GAP      | enforced idle gap before the next arbitration
module cdc_pulse_scheduler
   import cdc_sched_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int PAYLOAD_W = 8,
   parameter int TIMEOUT   = 64,
   parameter int GAP       = 2,
   parameter int ID_W      = $clog2(N_REQ)
) (
   input  logic                       clka_i,
   input  logic                       arst_n_i,
   input  logic [N_REQ-1:0]           req_i,
   input  logic [N_REQ*PAYLOAD_W-1:0] payload_i,
   output logic [N_REQ-1:0]           grant_o,
   output logic [N_REQ-1:0]           done_o,
   output logic [N_REQ-1:0]           err_o,
   output logic                       pulse_o,
   output logic [PAYLOAD_W-1:0]       hold_data_o,
   output logic [ID_W-1:0]            hold_id_o,
   input  logic                       ack_i,
   output logic                       busy_o,
   output logic                       stray_ack_o
);

   localparam int TMR_W = cnt_width(TIMEOUT);
   localparam int GAP_W = cnt_width(GAP);

   sched_state_e         state_q;
   logic [ID_W-1:0]      ptr_q;
   logic [ID_W-1:0]      hold_id_q;
   logic [PAYLOAD_W-1:0] hold_data_q;
   logic [N_REQ-1:0]     hold_oh_q;
   logic [TMR_W-1:0]     wait_cnt_q;
   logic [GAP_W-1:0]     gap_cnt_q;
   logic [N_REQ-1:0]     grant_q;
   logic [N_REQ-1:0]     done_q;
   logic [N_REQ-1:0]     err_q;
   logic                 pulse_q;
   logic                 stray_q;

   logic [N_REQ-1:0]     arb_gnt;
   logic [ID_W-1:0]      arb_idx;
   logic                 arb_vld;
   logic [PAYLOAD_W-1:0] sel_payload;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .vld_o (arb_vld)
   );

   always_comb begin
      sel_payload = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (arb_idx == ID_W'(k)) sel_payload = payload_i[k*PAYLOAD_W +: PAYLOAD_W];
      end
   end

   always_ff @(posedge clka_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q     <= ST_IDLE;
         ptr_q       <= ID_W'(N_REQ - 1);
         hold_id_q   <= '0;
         hold_data_q <= '0;
         hold_oh_q   <= '0;
         wait_cnt_q  <= '0;
         gap_cnt_q   <= '0;
         grant_q     <= '0;
         done_q      <= '0;
         err_q       <= '0;
         pulse_q     <= 1'b0;
         stray_q     <= 1'b0;
      end else begin
         grant_q <= '0;
         done_q  <= '0;
         err_q   <= '0;
         pulse_q <= 1'b0;
         stray_q <= ack_i && (state_q != ST_WAIT_ACK);
         case (state_q)
            ST_IDLE: begin
               if (arb_vld) begin
                  hold_data_q <= sel_payload;
                  hold_id_q   <= arb_idx;
                  hold_oh_q   <= arb_gnt;
                  ptr_q       <= arb_idx;
                  grant_q     <= arb_gnt;
                  pulse_q     <= 1'b1;
                  state_q     <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               wait_cnt_q <= '0;
               state_q    <= ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
               // An ack on the last allowed cycle still counts as success.
               if (ack_i) begin
                  done_q    <= hold_oh_q;
                  gap_cnt_q <= '0;
                  state_q   <= ST_GAP;
               end else if (wait_cnt_q == TMR_W'(TIMEOUT - 1)) begin
                  err_q     <= hold_oh_q;
                  gap_cnt_q <= '0;
                  state_q   <= ST_GAP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + TMR_W'(1);
               end
            end
            ST_GAP: begin
               if (gap_cnt_q == GAP_W'(GAP - 1)) state_q <= ST_IDLE;
               else gap_cnt_q <= gap_cnt_q + GAP_W'(1);
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign grant_o     = grant_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign pulse_o     = pulse_q;
   assign hold_data_o = hold_data_q;
   assign hold_id_o   = hold_id_q;
   assign stray_ack_o = stray_q;
   assign busy_o      = (state_q != ST_IDLE);

endmodule
